// File: rtl/stream_fifo.sv
// stream_fifo: first-word-fall-through FIFO with valid/ready on both sides.
// Storage is a DualPortRam with a registered read port. A read engine
// prefetches the oldest unread word into an output register.

module DualPortRam #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] wAddr,
  input  logic [DATA_WIDTH-1:0] dataIn,
  input  logic [ADDR_WIDTH-1:0] rAddr,
  output logic [DATA_WIDTH-1:0] q
);
  logic [DATA_WIDTH-1:0] mem [0:(1<<ADDR_WIDTH)-1];

  // Synchronous write; registered read returns old data on an address collision.
  always_ff @(posedge clk) begin
    if (we) mem[wAddr] <= dataIn;
    q <= mem[rAddr];
  end
endmodule

module stream_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  wrValid,
  output logic                  wrReady,
  input  logic [DATA_WIDTH-1:0] wrData,
  output logic                  rdValid,
  input  logic                  rdReady,
  output logic [DATA_WIDTH-1:0] rdData,
  output logic [ADDR_WIDTH:0]   count
);
  localparam int unsigned          DEPTH    = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] FULL_CNT = (ADDR_WIDTH+1)'(DEPTH);

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic [ADDR_WIDTH:0]   unread_q, unread_d;   // words in RAM not yet read
  logic                  inflight_q, inflight_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;

  logic                  push, pop, load_out, issue, ram_we;
  logic [ADDR_WIDTH-1:0] ram_raddr;
  logic [DATA_WIDTH-1:0] ram_q;

  assign wrReady = (count_q != FULL_CNT);
  assign rdValid = out_valid_q;
  assign rdData  = out_data_q;
  assign count   = count_q;

  DualPortRam #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .wAddr (wr_ptr_q),
    .dataIn(wrData),
    .rAddr (ram_raddr),
    .q     (ram_q)
  );

  // Handshakes, read engine and next-state for all registers.
  // A read left waiting in q holds rAddr on its own address (rd_ptr-1), so q
  // keeps returning that word until the output register can take it; this
  // allows a back-to-back read issue without a skid buffer. That slot is still
  // counted as occupied, so the writer never overwrites it while held.
  always_comb begin
    push      = wrValid && wrReady;
    pop       = out_valid_q && rdReady;
    load_out  = inflight_q && (!out_valid_q || pop);
    issue     = !flush && (unread_q != '0) && (!inflight_q || load_out);
    ram_we    = push && !flush;
    ram_raddr = issue ? rd_ptr_q : rd_ptr_q - ADDR_WIDTH'(1);

    wr_ptr_d    = push  ? wr_ptr_q + ADDR_WIDTH'(1) : wr_ptr_q;
    rd_ptr_d    = issue ? rd_ptr_q + ADDR_WIDTH'(1) : rd_ptr_q;
    count_d     = count_q;
    unread_d    = unread_q;
    inflight_d  = issue ? 1'b1 : (load_out ? 1'b0 : inflight_q);
    out_valid_d = load_out ? 1'b1 : (pop ? 1'b0 : out_valid_q);
    out_data_d  = load_out ? ram_q : out_data_q;

    case ({push, pop})
      2'b10:   count_d = count_q + (ADDR_WIDTH+1)'(1);
      2'b01:   count_d = count_q - (ADDR_WIDTH+1)'(1);
      default: count_d = count_q;
    endcase
    case ({push, issue})
      2'b10:   unread_d = unread_q + (ADDR_WIDTH+1)'(1);
      2'b01:   unread_d = unread_q - (ADDR_WIDTH+1)'(1);
      default: unread_d = unread_q;
    endcase

    if (flush) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      unread_d    = '0;
      inflight_d  = 1'b0;
      out_valid_d = 1'b0;
      out_data_d  = '0;
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      unread_q    <= '0;
      inflight_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      unread_q    <= unread_d;
      inflight_q  <= inflight_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end
endmodule
